// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: steers each accepted input beat into one of
// four 1-entry output buffers, chosen by i_sel (manual) or a round-robin pointer (auto).
module tdm_demux4 #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_auto_mode,
  input  logic [1:0]       i_sel,
  input  logic             i_in_valid,
  input  logic [W-1:0]     i_in_data,
  output logic             o_in_ready,
  output logic [3:0]       o_out_valid,
  input  logic [3:0]       i_out_ready,
  output logic [4*W-1:0]   o_out_data,
  output logic [1:0]       o_ptr,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_cnt
);

  logic [3:0]          r_valid;
  logic [3:0][W-1:0]   r_data;
  logic [1:0]          r_ptr;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic [1:0]          w_tgt;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_frame_last;

  // Target selection and handshake; a buffer draining this cycle may be refilled at once.
  always_comb begin
    w_tgt        = 2'd0;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_frame_last = 1'b0;
    if (i_auto_mode) begin
      w_tgt = r_ptr;
    end else begin
      w_tgt = i_sel;
    end
    if (i_rst) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = ~r_valid[w_tgt] | i_out_ready[w_tgt];
    end
    w_accept     = i_in_valid & w_in_ready;
    w_frame_last = w_accept & i_auto_mode & (r_ptr == 2'd3);
  end

  // Channel buffers, round-robin pointer and frame bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= 4'b0000;
      r_data       <= '0;
      r_ptr        <= 2'd0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_tgt == 2'(k))) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= i_in_data;
        end else if (r_valid[k] && i_out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end else begin
          r_valid[k] <= r_valid[k];
        end
      end
      if (w_accept && i_auto_mode) begin
        r_ptr <= r_ptr + 2'd1;
      end else begin
        r_ptr <= r_ptr;
      end
      r_frame_done <= w_frame_last;
      // Saturate rather than wrap so a long-running count never reads as small.
      if (w_frame_last && (r_frame_cnt != {CNT_W{1'b1}})) begin
        r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_valid;
  assign o_out_data   = r_data;
  assign o_ptr        = r_ptr;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Table-driven bench for tdm_demux4 (CNT_W=2 so frame counter saturation is reachable).
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst, auto_mode, in_valid, in_ready, frame_done;
  logic [1:0] sel, ptr, frame_cnt;
  logic [7:0] in_data;
  logic [3:0] out_valid, out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int ch1_beats = 0;

  typedef struct {
    logic       rst, am;
    logic [1:0] sel;
    logic       iv;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic [1:0] e_ptr;
    logic       e_fd;
    logic [1:0] e_cnt;
    logic [1:0] ch;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vq[$];

  tdm_demux4 #(.W(8), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_auto_mode(auto_mode), .i_sel(sel),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_ptr(ptr), .o_frame_done(frame_done), .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid[1] && out_ready[1]) ch1_beats = ch1_beats + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic am, input logic [1:0] s, input logic iv,
                     input logic [7:0] d, input logic [3:0] ordy, input logic e_rdy,
                     input logic [3:0] e_ov, input logic [1:0] e_ptr, input logic e_fd,
                     input logic [1:0] e_cnt, input logic [1:0] ch, input logic [7:0] e_dat);
    vec_t v;
    v = '{r, am, s, iv, d, ordy, e_rdy, e_ov, e_ptr, e_fd, e_cnt, ch, e_dat};
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; auto_mode = 1'b0; sel = 2'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
    //   rst am sel iv data   ordy    rdy  ov      ptr  fd   cnt  ch   dat
    add(1'b1,1'b0,2'd0,1'b1,8'hAA,4'b0000,1'b0,4'b0000,2'd0,1'b0,2'd0,2'd0,8'h00);
    add(1'b1,1'b0,2'd0,1'b1,8'hAA,4'b0000,1'b0,4'b0000,2'd0,1'b0,2'd0,2'd0,8'h00);
    add(1'b0,1'b0,2'd2,1'b1,8'h11,4'b0000,1'b1,4'b0100,2'd0,1'b0,2'd0,2'd2,8'h11);
    add(1'b0,1'b0,2'd0,1'b1,8'h22,4'b0000,1'b1,4'b0101,2'd0,1'b0,2'd0,2'd0,8'h22);
    add(1'b0,1'b0,2'd2,1'b1,8'h55,4'b0000,1'b0,4'b0101,2'd0,1'b0,2'd0,2'd2,8'h11);
    add(1'b0,1'b0,2'd1,1'b1,8'h33,4'b0000,1'b1,4'b0111,2'd0,1'b0,2'd0,2'd1,8'h33);
    add(1'b0,1'b0,2'd1,1'b1,8'h44,4'b0010,1'b1,4'b0111,2'd0,1'b0,2'd0,2'd1,8'h44);
    add(1'b0,1'b0,2'd1,1'b0,8'h00,4'b0010,1'b1,4'b0101,2'd0,1'b0,2'd0,2'd1,8'h44);
    add(1'b0,1'b0,2'd0,1'b0,8'h00,4'b1111,1'b1,4'b0000,2'd0,1'b0,2'd0,2'd0,8'h22);
    add(1'b0,1'b1,2'd0,1'b1,8'h01,4'b1111,1'b1,4'b0001,2'd1,1'b0,2'd0,2'd0,8'h01);
    add(1'b0,1'b1,2'd0,1'b1,8'h02,4'b1111,1'b1,4'b0010,2'd2,1'b0,2'd0,2'd1,8'h02);
    add(1'b0,1'b1,2'd0,1'b1,8'h03,4'b1111,1'b1,4'b0100,2'd3,1'b0,2'd0,2'd2,8'h03);
    add(1'b0,1'b1,2'd0,1'b1,8'h04,4'b1111,1'b1,4'b1000,2'd0,1'b1,2'd1,2'd3,8'h04);
    add(1'b0,1'b1,2'd0,1'b1,8'h05,4'b1111,1'b1,4'b0001,2'd1,1'b0,2'd1,2'd0,8'h05);
    add(1'b0,1'b1,2'd0,1'b1,8'h06,4'b1111,1'b1,4'b0010,2'd2,1'b0,2'd1,2'd1,8'h06);
    add(1'b0,1'b1,2'd0,1'b1,8'h07,4'b1111,1'b1,4'b0100,2'd3,1'b0,2'd1,2'd2,8'h07);
    add(1'b0,1'b1,2'd0,1'b1,8'h08,4'b1111,1'b1,4'b1000,2'd0,1'b1,2'd2,2'd3,8'h08);
    add(1'b0,1'b1,2'd0,1'b0,8'h00,4'b1111,1'b1,4'b0000,2'd0,1'b0,2'd2,2'd3,8'h08);
    add(1'b0,1'b0,2'd2,1'b1,8'h0B,4'b0000,1'b1,4'b0100,2'd0,1'b0,2'd2,2'd2,8'h0B);
    add(1'b0,1'b1,2'd0,1'b1,8'h09,4'b0000,1'b1,4'b0101,2'd1,1'b0,2'd2,2'd0,8'h09);
    add(1'b0,1'b1,2'd0,1'b1,8'h0A,4'b0000,1'b1,4'b0111,2'd2,1'b0,2'd2,2'd1,8'h0A);
    add(1'b0,1'b1,2'd0,1'b1,8'h0C,4'b0000,1'b0,4'b0111,2'd2,1'b0,2'd2,2'd2,8'h0B);
    add(1'b0,1'b1,2'd0,1'b1,8'h0C,4'b0100,1'b1,4'b0111,2'd3,1'b0,2'd2,2'd2,8'h0C);
    add(1'b0,1'b1,2'd0,1'b1,8'h0D,4'b0000,1'b1,4'b1111,2'd0,1'b1,2'd3,2'd3,8'h0D);
    add(1'b0,1'b1,2'd0,1'b0,8'h00,4'b1111,1'b1,4'b0000,2'd0,1'b0,2'd3,2'd3,8'h0D);
    add(1'b0,1'b1,2'd0,1'b1,8'h0E,4'b1111,1'b1,4'b0001,2'd1,1'b0,2'd3,2'd0,8'h0E);
    add(1'b0,1'b0,2'd3,1'b1,8'h21,4'b1111,1'b1,4'b1000,2'd1,1'b0,2'd3,2'd3,8'h21);
    add(1'b0,1'b0,2'd3,1'b1,8'h22,4'b1111,1'b1,4'b1000,2'd1,1'b0,2'd3,2'd3,8'h22);
    add(1'b0,1'b0,2'd0,1'b1,8'h23,4'b1111,1'b1,4'b0001,2'd1,1'b0,2'd3,2'd0,8'h23);
    add(1'b0,1'b1,2'd0,1'b1,8'h0F,4'b1111,1'b1,4'b0010,2'd2,1'b0,2'd3,2'd1,8'h0F);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; auto_mode = vq[i].am; sel = vq[i].sel; in_valid = vq[i].iv;
      in_data = vq[i].d; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("in_ready[%0d]", i), int'(in_ready), int'(vq[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("out_valid[%0d]", i), int'(out_valid), int'(vq[i].e_ov));
      chk($sformatf("ptr[%0d]", i), int'(ptr), int'(vq[i].e_ptr));
      chk($sformatf("frame_done[%0d]", i), int'(frame_done), int'(vq[i].e_fd));
      chk($sformatf("frame_cnt[%0d]", i), int'(frame_cnt), int'(vq[i].e_cnt));
      chk($sformatf("out_data[%0d]", i), int'(out_data[vq[i].ch*8 +: 8]), int'(vq[i].e_dat));
      if (i == 8) chk("ch1_beats", ch1_beats, 2);
    end

    // Five more auto frames from ptr=2 with all consumers ready: counter stays saturated.
    rst = 1'b0; auto_mode = 1'b1; in_valid = 1'b1; out_ready = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] pb;
      pb = 2'((2 + i) % 4);
      in_data = 8'(8'h40 + i);
      #1;
      chk($sformatf("sat_rdy[%0d]", i), int'(in_ready), 1);
      @(posedge clk); #1;
      chk($sformatf("sat_fd[%0d]", i), int'(frame_done), (pb == 2'd3) ? 1 : 0);
      chk($sformatf("sat_ptr[%0d]", i), int'(ptr), (2 + i + 1) % 4);
      chk($sformatf("sat_dat[%0d]", i), int'(out_data[pb*8 +: 8]), 8'h40 + i);
    end
    chk("sat_cnt", int'(frame_cnt), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
